// File: rtl/m_ctrl_fsm.sv
// Multicycle MIPS-subset control unit: decodes IR + zero into the per-state
// control word for M_datapath, with MIO handshake gating on memory states.
module m_ctrl_fsm #(
  parameter int N_STATE_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          Inst,
  input  logic                 zero,
  input  logic                 MIO_ready,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 Branch,
  output logic                 IorD,
  output logic                 IRWrite,
  output logic                 MemRW,
  output logic                 CPU_MIO,
  output logic [1:0]           MemtoReg,
  output logic [1:0]           RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           PCSource,
  output logic [2:0]           ALU_operation,
  output logic                 illegal,
  output logic [N_STATE_W-1:0] state_out
);

  typedef enum logic [3:0] {
    S_IF  = 4'd0,  S_ID  = 4'd1,  S_MA  = 4'd2,  S_MR  = 4'd3,
    S_LWB = 4'd4,  S_MW  = 4'd5,  S_REX = 4'd6,  S_RWB = 4'd7,
    S_BR  = 4'd8,  S_J   = 4'd9,  S_IEX = 4'd10, S_IWB = 4'd11,
    S_JAL = 4'd12, S_JR  = 4'd13, S_LUI = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011,
                         OP_SW    = 6'b101011, OP_BEQ = 6'b000100,
                         OP_BNE   = 6'b000101, OP_J   = 6'b000010,
                         OP_JAL   = 6'b000011, OP_LUI = 6'b001111,
                         FN_JR    = 6'b001000;

  state_t     state, nxt;
  logic [5:0] opcode, funct;
  logic       r_ok, i_ok, id_ok;
  logic [2:0] r_op, i_op;
  logic       unused_bits;

  assign opcode      = Inst[31:26];
  assign funct       = Inst[5:0];
  // zero is consumed by the datapath's PCWriteCond qualifier, not here
  assign unused_bits = ^{zero, Inst[25:6]};
  assign state_out   = N_STATE_W'(state);

  always_comb begin
    r_ok = 1'b1;
    r_op = 3'b010;
    case (funct)
      6'b100000: r_op = 3'b010;
      6'b100010: r_op = 3'b110;
      6'b100100: r_op = 3'b000;
      6'b100101: r_op = 3'b001;
      6'b100110: r_op = 3'b011;
      6'b100111: r_op = 3'b100;
      6'b101010: r_op = 3'b111;
      6'b000010: r_op = 3'b101;
      default:   r_ok = 1'b0;
    endcase
    i_ok = 1'b1;
    i_op = 3'b010;
    case (opcode)
      6'b001000: i_op = 3'b010;
      6'b001010: i_op = 3'b111;
      6'b001100: i_op = 3'b000;
      6'b001101: i_op = 3'b001;
      default:   i_ok = 1'b0;
    endcase
    case (opcode)
      OP_RTYPE:                                      id_ok = r_ok || (funct == FN_JR);
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_LUI: id_ok = 1'b1;
      default:                                       id_ok = i_ok;
    endcase
  end

  always_comb begin
    nxt = S_IF;
    case (state)
      S_IF: nxt = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        if (!id_ok) nxt = S_IF;
        else begin
          case (opcode)
            OP_RTYPE:     nxt = (funct == FN_JR) ? S_JR : S_REX;
            OP_LW, OP_SW: nxt = S_MA;
            OP_BEQ, OP_BNE: nxt = S_BR;
            OP_J:         nxt = S_J;
            OP_JAL:       nxt = S_JAL;
            OP_LUI:       nxt = S_LUI;
            default:      nxt = S_IEX;
          endcase
        end
      end
      S_MA:  nxt = (opcode == OP_SW) ? S_MW : S_MR;
      S_MR:  nxt = MIO_ready ? S_LWB : S_MR;
      S_MW:  nxt = MIO_ready ? S_IF : S_MW;
      S_REX: nxt = S_RWB;
      S_IEX: nxt = S_IWB;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IF;
    else        state <= nxt;
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    MemRW         = 1'b0;
    CPU_MIO       = 1'b0;
    MemtoReg      = 2'b00;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    ALU_operation = 3'b010;
    illegal       = 1'b0;
    case (state)
      S_IF: begin
        CPU_MIO = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = MIO_ready;
        IRWrite = MIO_ready;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        illegal = !id_ok;
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MR: begin
        CPU_MIO = 1'b1;
        IorD    = 1'b1;
      end
      S_LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      S_MW: begin
        CPU_MIO = 1'b1;
        IorD    = 1'b1;
        MemRW   = MIO_ready;
      end
      S_REX: begin
        ALUSrcA       = 1'b1;
        ALU_operation = r_op;
      end
      S_RWB: begin
        RegWrite      = 1'b1;
        RegDst        = 2'b01;
        ALU_operation = r_op;
      end
      S_BR: begin
        ALUSrcA       = 1'b1;
        ALU_operation = 3'b110;
        PCWriteCond   = 1'b1;
        PCSource      = 2'b01;
        Branch        = (opcode == OP_BEQ);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_JAL: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        RegWrite = 1'b1;
        RegDst   = 2'b10;
        MemtoReg = 2'b11;
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'b11;
      end
      S_IEX: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 2'b10;
        ALU_operation = i_op;
      end
      S_IWB: begin
        RegWrite      = 1'b1;
        ALU_operation = i_op;
      end
      S_LUI: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      default: ;
    endcase
    // state already reads IF during reset; only the enables need masking
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRW       = 1'b0;
      CPU_MIO     = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule
